// File: rtl/nv_nvdla_glb_intr_reg_gen.sv
// Global interrupt register block: version, mask, sticky W1C status, SW set,
// global enable and per-source saturating event counters on the CSB path.
module nv_nvdla_glb_intr_reg_gen #(
    parameter int          NUM_SRC  = 12,
    parameter int          CNT_W    = 8,
    parameter logic [7:0]  HW_MAJOR = 8'h31,
    parameter logic [15:0] HW_MINOR = 16'h3030
) (
    input  logic               nvdla_core_clk,
    input  logic               nvdla_core_rst,
    input  logic [11:0]        reg_offset,
    input  logic [31:0]        reg_wr_data,
    input  logic               reg_wr_en,
    output logic [31:0]        reg_rd_data,
    input  logic [NUM_SRC-1:0] src_done,
    output logic [NUM_SRC-1:0] intr_mask,
    output logic [NUM_SRC-1:0] intr_status,
    output logic               core_intr
);

    generate
        if (CNT_W < 1 || CNT_W > 32) begin : g_bad_cnt_w
            $error("nv_nvdla_glb_intr_reg_gen: CNT_W must be within 1..32");
        end
        if (NUM_SRC < 1 || NUM_SRC > 32) begin : g_bad_num_src
            $error("nv_nvdla_glb_intr_reg_gen: NUM_SRC must be within 1..32");
        end
    endgenerate

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    function automatic logic [11:0] cnt_offset(input int idx);
        return 12'h100 + 12'(idx * 4);
    endfunction

    logic [NUM_SRC-1:0] mask_r;
    logic [NUM_SRC-1:0] status_r;
    logic               glb_en_r;
    logic               core_intr_r;
    logic [CNT_W-1:0]   evt_cnt_r [NUM_SRC];

    logic               wr_mask_s;
    logic               wr_ctrl_s;
    logic               cnt_clr_s;
    logic [NUM_SRC-1:0] set_s;
    logic [NUM_SRC-1:0] w1c_s;
    logic [31:0]        rd_data_s;
    logic               unused_wr_bits_s;

    assign wr_mask_s        = reg_wr_en & (reg_offset == 12'h004);
    assign wr_ctrl_s        = reg_wr_en & (reg_offset == 12'h014);
    assign cnt_clr_s        = wr_ctrl_s & reg_wr_data[1];
    assign set_s            = (reg_wr_en & (reg_offset == 12'h008)) ? reg_wr_data[NUM_SRC-1:0] : {NUM_SRC{1'b0}};
    assign w1c_s            = (reg_wr_en & (reg_offset == 12'h00C)) ? reg_wr_data[NUM_SRC-1:0] : {NUM_SRC{1'b0}};
    assign unused_wr_bits_s = ^reg_wr_data;

    // Control/status flops; any set in the same cycle as a W1C clear wins.
    always_ff @(posedge nvdla_core_clk) begin
        if (nvdla_core_rst) begin
            mask_r      <= {NUM_SRC{1'b1}};
            status_r    <= {NUM_SRC{1'b0}};
            glb_en_r    <= 1'b0;
            core_intr_r <= 1'b0;
        end else begin
            status_r    <= (status_r & ~w1c_s) | src_done | set_s;
            if (wr_mask_s) begin
                mask_r <= reg_wr_data[NUM_SRC-1:0];
            end
            if (wr_ctrl_s) begin
                glb_en_r <= reg_wr_data[0];
            end
            core_intr_r <= glb_en_r & (|(status_r & ~mask_r));
        end
    end

    // Saturating hardware event counters; a clear drops a coincident event.
    always_ff @(posedge nvdla_core_clk) begin
        for (int i = 0; i < NUM_SRC; i++) begin
            if (nvdla_core_rst || cnt_clr_s) begin
                evt_cnt_r[i] <= {CNT_W{1'b0}};
            end else if (src_done[i] && (evt_cnt_r[i] != CNT_MAX)) begin
                evt_cnt_r[i] <= evt_cnt_r[i] + CNT_W'(1'b1);
            end
        end
    end

    // Read mux; unmapped offsets and write-only registers return zero.
    always_comb begin
        rd_data_s = 32'h0000_0000;
        case (reg_offset)
            12'h000: rd_data_s = {8'h00, HW_MINOR, HW_MAJOR};
            12'h004: rd_data_s = 32'(mask_r);
            12'h00C: rd_data_s = 32'(status_r);
            12'h010: rd_data_s = 32'(status_r & ~mask_r);
            12'h014: rd_data_s = {31'h0000_0000, glb_en_r};
            default: begin
                for (int i = 0; i < NUM_SRC; i++) begin
                    rd_data_s = rd_data_s |
                        ((reg_offset == cnt_offset(i)) ? 32'(evt_cnt_r[i]) : 32'h0000_0000);
                end
            end
        endcase
    end

    assign reg_rd_data = rd_data_s;
    assign intr_mask   = mask_r;
    assign intr_status = status_r;
    assign core_intr   = core_intr_r;

endmodule

// File: tb/tb_nv_nvdla_glb_intr_reg_gen.sv
// Table-driven bench for nv_nvdla_glb_intr_reg_gen with a queue scoreboard
// and hand-written sequences for saturation, counter clear and reset.
module tb_nv_nvdla_glb_intr_reg_gen;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [11:0] reg_offset = 12'h000;
    logic [31:0] reg_wr_data = 32'h0;
    logic        reg_wr_en = 1'b0;
    logic [31:0] reg_rd_data;
    logic [11:0] src_done = 12'h000;
    logic [11:0] intr_mask;
    logic [11:0] intr_status;
    logic        core_intr;

    nv_nvdla_glb_intr_reg_gen #(
        .NUM_SRC (12),
        .CNT_W   (8),
        .HW_MAJOR(8'h31),
        .HW_MINOR(16'h3030)
    ) dut (
        .nvdla_core_clk(clk),
        .nvdla_core_rst(rst),
        .reg_offset    (reg_offset),
        .reg_wr_data   (reg_wr_data),
        .reg_wr_en     (reg_wr_en),
        .reg_rd_data   (reg_rd_data),
        .src_done      (src_done),
        .intr_mask     (intr_mask),
        .intr_status   (intr_status),
        .core_intr     (core_intr)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        int          sel;
        logic [31:0] val;
    } exp_t;

    typedef struct packed {
        logic        wr;
        logic [11:0] off;
        logic [31:0] data;
        logic [11:0] done;
        logic [11:0] chk;
        logic [31:0] exp_rd;
        logic        exp_intr;
    } vec_t;

    exp_t exp_q[$];
    vec_t vt[26];
    int   n_checks = 0;
    int   n_pass   = 0;

    task automatic push_exp(input string name, input int sel, input logic [31:0] val);
        exp_t e;
        e.name = name;
        e.sel  = sel;
        e.val  = val;
        exp_q.push_back(e);
    endtask

    task automatic drain();
        exp_t        e;
        logic [31:0] act;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            case (e.sel)
                0:       act = reg_rd_data;
                1:       act = {31'h0, core_intr};
                2:       act = {20'h0, intr_status};
                default: act = {20'h0, intr_mask};
            endcase
            n_checks++;
            if (act === e.val) n_pass++;
            else $display("FAIL %s: got 0x%08h expected 0x%08h", e.name, act, e.val);
        end
    endtask

    task automatic cyc(input logic wr, input logic [11:0] off, input logic [31:0] data,
                       input logic [11:0] done);
        reg_wr_en   = wr;
        reg_offset  = off;
        reg_wr_data = data;
        src_done    = done;
        @(posedge clk);
        #1;
        reg_wr_en   = 1'b0;
        reg_wr_data = 32'h0;
        src_done    = 12'h000;
    endtask

    task automatic rd_chk(input string name, input logic [11:0] off, input logic [31:0] exp);
        push_exp(name, 0, exp);
        reg_offset = off;
        #1;
        drain();
    endtask

    task automatic port_chk(input string name, input int sel, input logic [31:0] exp);
        push_exp(name, sel, exp);
        #1;
        drain();
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        //             wr    off      data           done     chk      exp_rd         intr
        vt[0]  = '{1'b1, 12'h014, 32'h0000_0001, 12'h000, 12'h014, 32'h0000_0001, 1'b0};
        vt[1]  = '{1'b1, 12'h004, 32'h0000_0000, 12'h000, 12'h004, 32'h0000_0000, 1'b0};
        vt[2]  = '{1'b0, 12'h000, 32'h0000_0000, 12'h008, 12'h00C, 32'h0000_0008, 1'b0};
        vt[3]  = '{1'b0, 12'h000, 32'h0000_0000, 12'h000, 12'h10C, 32'h0000_0001, 1'b1};
        vt[4]  = '{1'b1, 12'h00C, 32'h0000_0008, 12'h000, 12'h00C, 32'h0000_0000, 1'b1};
        vt[5]  = '{1'b0, 12'h000, 32'h0000_0000, 12'h000, 12'h010, 32'h0000_0000, 1'b0};
        vt[6]  = '{1'b1, 12'h00C, 32'h0000_0008, 12'h008, 12'h00C, 32'h0000_0008, 1'b0};
        vt[7]  = '{1'b0, 12'h000, 32'h0000_0000, 12'h000, 12'h10C, 32'h0000_0002, 1'b1};
        vt[8]  = '{1'b1, 12'h00C, 32'h0000_0008, 12'h000, 12'h00C, 32'h0000_0000, 1'b1};
        vt[9]  = '{1'b1, 12'h004, 32'h0000_0FFF, 12'h000, 12'h004, 32'h0000_0FFF, 1'b0};
        vt[10] = '{1'b1, 12'h008, 32'h0000_0801, 12'h000, 12'h00C, 32'h0000_0801, 1'b0};
        vt[11] = '{1'b0, 12'h000, 32'h0000_0000, 12'h000, 12'h010, 32'h0000_0000, 1'b0};
        vt[12] = '{1'b1, 12'h004, 32'h0000_07FF, 12'h000, 12'h010, 32'h0000_0800, 1'b0};
        vt[13] = '{1'b0, 12'h000, 32'h0000_0000, 12'h000, 12'h008, 32'h0000_0000, 1'b1};
        vt[14] = '{1'b0, 12'h000, 32'h0000_0000, 12'h000, 12'h100, 32'h0000_0000, 1'b1};
        vt[15] = '{1'b1, 12'h000, 32'hFFFF_FFFF, 12'h000, 12'h000, 32'h0030_3031, 1'b1};
        vt[16] = '{1'b1, 12'h010, 32'hFFFF_FFFF, 12'h000, 12'h00C, 32'h0000_0801, 1'b1};
        vt[17] = '{1'b1, 12'h00C, 32'hFFFF_F801, 12'h000, 12'h00C, 32'h0000_0000, 1'b1};
        vt[18] = '{1'b1, 12'h014, 32'h0000_0000, 12'h001, 12'h014, 32'h0000_0000, 1'b0};
        vt[19] = '{1'b0, 12'h000, 32'h0000_0000, 12'h000, 12'h00C, 32'h0000_0001, 1'b0};
        vt[20] = '{1'b1, 12'h004, 32'hFFFF_F000, 12'h000, 12'h004, 32'h0000_0000, 1'b0};
        vt[21] = '{1'b0, 12'h000, 32'h0000_0000, 12'h000, 12'h010, 32'h0000_0001, 1'b0};
        vt[22] = '{1'b1, 12'h014, 32'h0000_0001, 12'h000, 12'h014, 32'h0000_0001, 1'b0};
        vt[23] = '{1'b0, 12'h000, 32'h0000_0000, 12'h000, 12'h01C, 32'h0000_0000, 1'b1};
        vt[24] = '{1'b1, 12'h00C, 32'h0000_0001, 12'h000, 12'h130, 32'h0000_0000, 1'b1};
        vt[25] = '{1'b0, 12'h000, 32'h0000_0000, 12'h000, 12'h102, 32'h0000_0000, 1'b0};

        cyc(1'b0, 12'h000, 32'h0, 12'h000);
        cyc(1'b0, 12'h000, 32'h0, 12'h000);
        rst = 1'b0;

        rd_chk("rst_hw_version", 12'h000, 32'h0030_3031);
        rd_chk("rst_mask",       12'h004, 32'h0000_0FFF);
        rd_chk("rst_status",     12'h00C, 32'h0000_0000);
        rd_chk("rst_ctrl",       12'h014, 32'h0000_0000);
        port_chk("rst_core_intr", 1, 32'h0);

        for (int i = 0; i < 26; i++) begin
            push_exp($sformatf("vec%0d_rd_0x%03h", i, vt[i].chk), 0, vt[i].exp_rd);
            push_exp($sformatf("vec%0d_core_intr", i), 1, {31'h0, vt[i].exp_intr});
            cyc(vt[i].wr, vt[i].off, vt[i].data, vt[i].done);
            reg_offset = vt[i].chk;
            #1;
            drain();
        end
        port_chk("mask_port", 3, 32'h0);
        port_chk("status_port", 2, 32'h0);

        // counter 0 holds 1 from the table; it must stop at 0xFF
        for (int i = 0; i < 100; i++) cyc(1'b0, 12'h000, 32'h0, 12'h001);
        rd_chk("cnt0_mid", 12'h100, 32'h0000_0065);
        for (int i = 0; i < 200; i++) cyc(1'b0, 12'h000, 32'h0, 12'h001);
        rd_chk("cnt0_sat", 12'h100, 32'h0000_00FF);
        port_chk("sat_core_intr", 1, 32'h1);

        cyc(1'b1, 12'h014, 32'h0000_0003, 12'h001);
        rd_chk("cnt0_clr",     12'h100, 32'h0000_0000);
        rd_chk("cnt3_clr",     12'h10C, 32'h0000_0000);
        rd_chk("clr_glb_en",   12'h014, 32'h0000_0001);

        cyc(1'b1, 12'h008, 32'h0000_0FFF, 12'h001);
        cyc(1'b0, 12'h000, 32'h0, 12'h000);
        port_chk("pre_rst_status", 2, 32'h0000_0FFF);
        port_chk("pre_rst_intr",   1, 32'h1);
        rd_chk("pre_rst_cnt0", 12'h100, 32'h0000_0001);

        rst = 1'b1;
        cyc(1'b0, 12'h000, 32'h0, 12'hFFF);
        port_chk("rst_mid_status", 2, 32'h0);
        port_chk("rst_mid_mask",   3, 32'h0000_0FFF);
        port_chk("rst_mid_intr",   1, 32'h0);
        rd_chk("rst_mid_cnt0",  12'h100, 32'h0);
        rd_chk("rst_mid_cnt11", 12'h12C, 32'h0);
        rd_chk("rst_mid_ctrl",  12'h014, 32'h0);
        rst = 1'b0;
        cyc(1'b0, 12'h000, 32'h0, 12'h000);
        port_chk("post_rst_status", 2, 32'h0);
        port_chk("post_rst_intr",   1, 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
